// File: rtl/stim_sequencer.sv
// rtl/stim_sequencer.sv - table-driven switch/button stimulus sequencer for a CPU front panel
// Optional: define STIM_SEQ_LOOP_EN to wrap to step 0 on an end entry instead of finishing.
module stim_sequencer #(
    parameter int SW_W      = 16,
    parameter int DEPTH     = 16,
    parameter int DELAY_W   = 8,
    parameter int PULSE_LEN = 4,
    localparam int ENTRY_W  = SW_W + DELAY_W + 3,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic               abort,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic [SW_W-1:0]    S,
    output logic               Run,
    output logic               Continue,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      step_idx
);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int CW = ENTRY_W - DELAY_W;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, APPLY, PULSE, NEXT, DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ENTRY_W-1:0]   r_table [DEPTH];
    logic [CW-1:0]        r_entry;
    logic [AW-1:0]        r_idx;
    logic [DELAY_W-1:0]   r_cnt;
    logic [PW-1:0]        r_pcnt;
    logic [SW_W-1:0]      r_S;

    logic [ENTRY_W-1:0]   w_rd;
    logic [DELAY_W-1:0]   w_rd_delay;
    logic                 w_end;
    logic                 w_pcont;
    logic                 w_prun;
    logic [SW_W-1:0]      w_sw;

    // Only the control/switch part of an entry is latched; the delay goes straight to r_cnt.
    assign w_rd       = r_table[r_idx];
    assign w_rd_delay = w_rd[DELAY_W-1:0];
    assign w_end      = r_entry[CW-1];
    assign w_pcont    = r_entry[CW-2];
    assign w_prun     = r_entry[CW-3];
    assign w_sw       = r_entry[SW_W-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = LOAD;
            LOAD:       w_next = (w_rd_delay != '0) ? WAIT : APPLY;
            WAIT:       if (r_cnt == DELAY_W'(1)) w_next = APPLY;
            APPLY:      w_next = (w_prun || w_pcont) ? PULSE : NEXT;
            PULSE:      if (r_pcnt == PW'(PULSE_LEN - 1)) w_next = NEXT;
`ifdef STIM_SEQ_LOOP_EN
            NEXT:       w_next = LOAD;
`else
            NEXT:       w_next = (w_end || r_idx == AW'(DEPTH - 1)) ? DONE : LOAD;
`endif
            default:    w_next = IDLE;
        endcase
        if (abort) w_next = IDLE;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_S     <= '0;
            r_entry <= '0;
        end else begin
            r_state <= w_next;
            if (!abort) begin
                case (r_state)
                    IDLE, DONE: if (start) r_idx <= '0;
                    LOAD: begin
                        r_entry <= w_rd[ENTRY_W-1:DELAY_W];
                        r_cnt   <= w_rd_delay;
                    end
                    WAIT:  r_cnt <= r_cnt - DELAY_W'(1);
                    APPLY: begin
                        r_S    <= w_sw;
                        r_pcnt <= '0;
                    end
                    PULSE: r_pcnt <= r_pcnt + PW'(1);
`ifdef STIM_SEQ_LOOP_EN
                    NEXT:  r_idx <= w_end ? '0 : r_idx + AW'(1);
`else
                    NEXT:  if (w_next == LOAD) r_idx <= r_idx + AW'(1);
`endif
                    default: ;
                endcase
            end
        end
    end

    // The table survives reset; writes are only accepted while the sequencer is parked.
    always_ff @(posedge Clk) begin
        if (wr_en && !busy) r_table[wr_addr] <= wr_data;
    end

    assign busy     = (r_state != IDLE) && (r_state != DONE);
    assign done     = (r_state == DONE);
    assign Run      = !((r_state == PULSE) && w_prun);
    assign Continue = !((r_state == PULSE) && w_pcont);
    assign S        = r_S;
    assign step_idx = r_idx;
endmodule

// File: tb/tb_stim_sequencer.sv
// tb/tb_stim_sequencer.sv - randomized self-checking bench for stim_sequencer against a step-timing model
module tb_stim_sequencer;
    localparam int SW_W = 16, DEPTH = 16, DELAY_W = 8, PULSE_LEN = 4;
    localparam int ENTRY_W = SW_W + DELAY_W + 3, AW = 4, LIMIT = 600;

    logic               Clk = 1'b0, Reset = 1'b0, start = 1'b0, abort = 1'b0, wr_en = 1'b0;
    logic [AW-1:0]      wr_addr = '0;
    logic [ENTRY_W-1:0] wr_data = '0;
    logic [SW_W-1:0]    S;
    logic               Run, Continue, busy, done;
    logic [AW-1:0]      step_idx;

    stim_sequencer #(.SW_W(SW_W), .DEPTH(DEPTH), .DELAY_W(DELAY_W), .PULSE_LEN(PULSE_LEN)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .abort(abort), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .S(S), .Run(Run), .Continue(Continue),
        .busy(busy), .done(done), .step_idx(step_idx));

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [SW_W-1:0] s;
        logic            run;
        logic            cont;
        logic            busy;
        logic            done;
        logic [AW-1:0]   idx;
    } exp_t;

    int                 checks = 0, errors = 0;
    logic [ENTRY_W-1:0] tbl [DEPTH];
    logic [SW_W-1:0]    exp_s = '0;
    exp_t               q[$];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [ENTRY_W-1:0] mk(input bit e, input bit pc, input bit pr,
                                              input logic [SW_W-1:0] sw, input logic [DELAY_W-1:0] d);
        return {e, pc, pr, sw, d};
    endfunction

    task automatic push(input logic [SW_W-1:0] s, input bit run, input bit cont,
                        input bit bz, input bit dn, input int k);
        exp_t t;
        t.s = s; t.run = run; t.cont = cont; t.busy = bz; t.done = dn; t.idx = AW'(k);
        q.push_back(t);
    endtask

    // Per-cycle expectations from the step timing: 1 load + delay wait + 1 apply, optional pulse, 1 next.
    task automatic build_model(input int limit);
        int k;
        logic [SW_W-1:0] s;
        logic [ENTRY_W-1:0] e;
        bit fin;
        q.delete();
        s = exp_s; k = 0; fin = 0;
        while (!fin && q.size() < limit) begin
            e = tbl[k];
            for (int c = 0; c < int'(e[7:0]) + 2; c++) push(s, 1, 1, 1, 0, k);
            s = e[23:8];
            if (e[25] || e[24]) repeat (PULSE_LEN) push(s, !e[24], !e[25], 1, 0, k);
            push(s, 1, 1, 1, 0, k);
            if (e[26] || k == DEPTH - 1) begin
`ifdef STIM_SEQ_LOOP_EN
                k = 0;
`else
                push(s, 1, 1, 0, 1, k);
                fin = 1;
`endif
            end else begin
                k++;
            end
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [ENTRY_W-1:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
        tbl[a] = d;
    endtask

    task automatic run_check(input string nm, input int abort_at, input bit busy_wr,
                             input logic [AW-1:0] wa, input logic [ENTRY_W-1:0] wd);
        int i;
        exp_t last;
        start = 1;
        tick();
        start = 0; wr_en = 0;
        build_model(LIMIT);
        for (i = 0; i < q.size(); i++) begin
            checks++;
            if ({S, Run, Continue, busy, done, step_idx} !== q[i]) begin
                errors++;
                $display("FAIL %s cycle %0d got S=%h Run=%b Cont=%b busy=%b done=%b idx=%0d exp S=%h Run=%b Cont=%b busy=%b done=%b idx=%0d",
                         nm, i, S, Run, Continue, busy, done, step_idx,
                         q[i].s, q[i].run, q[i].cont, q[i].busy, q[i].done, q[i].idx);
            end
            if (i == abort_at || i == q.size() - 1) break;
            if (busy_wr && i == 1) begin
                wr_en = 1; wr_addr = wa; wr_data = wd;
            end
            tick();
            wr_en = 0;
        end
        last  = q[i];
        exp_s = last.s;
        if (last.done) begin
            tick();
            checks++;
            if ({busy, done, Run, Continue, S} !== {1'b0, 1'b1, 1'b1, 1'b1, exp_s}) begin
                errors++;
                $display("FAIL %s_done_hold got busy=%b done=%b Run=%b Cont=%b S=%h exp busy=0 done=1 Run=1 Cont=1 S=%h",
                         nm, busy, done, Run, Continue, S, exp_s);
            end
        end else begin
            abort = 1;
            tick();
            abort = 0;
            checks++;
            if ({busy, done, Run, Continue, S} !== {1'b0, 1'b0, 1'b1, 1'b1, exp_s}) begin
                errors++;
                $display("FAIL %s_abort got busy=%b done=%b Run=%b Cont=%b S=%h exp busy=0 done=0 Run=1 Cont=1 S=%h",
                         nm, busy, done, Run, Continue, S, exp_s);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 0;
        repeat (3) tick();
        checks++;
        if ({S, Run, Continue, busy, done, step_idx} !== {16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset got S=%h Run=%b Cont=%b busy=%b done=%b idx=%0d exp S=0 Run=1 Cont=1 busy=0 done=0 idx=0",
                     S, Run, Continue, busy, done, step_idx);
        end
        Reset = 1;
        exp_s = '0;
        tick();
    endtask

    task automatic test_directed();
        wr(0, mk(0, 0, 1, 16'h0003, 8'd2));
        wr(1, mk(1, 1, 0, 16'h0001, 8'd0));
        run_check("directed", -1, 0, 0, 0);
`ifndef STIM_SEQ_LOOP_EN
        checks++;
        if ({S, done} !== {16'h0001, 1'b1}) begin
            errors++;
            $display("FAIL directed_final got S=%h done=%b exp S=0001 done=1", S, done);
        end
`endif
    endtask

    task automatic test_reset_midrun();
        wr(0, mk(0, 0, 1, 16'h0003, 8'd2));
        wr(1, mk(1, 1, 0, 16'h0001, 8'd0));
        start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        checks++;
        if ({Run, S} !== {1'b0, 16'h0003}) begin
            errors++;
            $display("FAIL midrun_pulse got Run=%b S=%h exp Run=0 S=0003", Run, S);
        end
        Reset = 0;
        tick();
        Reset = 1;
        exp_s = '0;
        checks++;
        if ({Run, Continue, S, busy, done, step_idx} !== {1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL midrun_reset got Run=%b Cont=%b S=%h busy=%b done=%b idx=%0d exp Run=1 Cont=1 S=0 busy=0 done=0 idx=0",
                     Run, Continue, S, busy, done, step_idx);
        end
        run_check("rerun_after_reset", -1, 0, 0, 0);
    endtask

    task automatic test_start_abort();
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL start_abort got busy=%b done=%b exp busy=0 done=0", busy, done);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_stay got busy=%b exp 0", busy);
        end
        run_check("abort_mid", 5, 0, 0, 0);
    endtask

    task automatic test_write_busy();
        wr(0, mk(1, 0, 1, 16'h1234, 8'd1));
        run_check("wr_busy_run", -1, 1, 0, mk(1, 1, 0, 16'hBEEF, 8'd0));
        run_check("wr_busy_rerun", -1, 0, 0, 0);
    endtask

    task automatic test_write_with_start();
        wr_en = 1; wr_addr = 0; wr_data = mk(1, 1, 1, 16'h5A5A, 8'd3);
        tbl[0] = wr_data;
        run_check("wr_with_start", -1, 0, 0, 0);
    endtask

    task automatic test_random();
        int ab;
        repeat (6) begin
            for (int k = 0; k < DEPTH; k++)
                wr(AW'(k), mk($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                              16'($urandom), 8'($urandom_range(0, 5))));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            run_check("random", ab, 0, 0, 0);
        end
    endtask

    task automatic test_no_wrap();
        for (int k = 0; k < DEPTH; k++)
            wr(AW'(k), mk(0, 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom_range(0, 2))));
        run_check("no_wrap", -1, 0, 0, 0);
`ifndef STIM_SEQ_LOOP_EN
        checks++;
        if ({step_idx, done} !== {4'd15, 1'b1}) begin
            errors++;
            $display("FAIL no_wrap_final got idx=%0d done=%b exp idx=15 done=1", step_idx, done);
        end
`endif
    endtask

`ifdef STIM_SEQ_LOOP_EN
    task automatic test_loop();
        wr(0, mk(0, 0, 1, 16'h00A0, 8'd1));
        wr(1, mk(1, 1, 0, 16'h00B1, 8'd0));
        run_check("loop", 40, 0, 0, 0);
    endtask
`endif

    initial begin
        for (int k = 0; k < DEPTH; k++) tbl[k] = '0;
        test_reset();
        test_directed();
        test_reset_midrun();
        test_start_abort();
        test_write_busy();
        test_write_with_start();
        test_random();
        test_no_wrap();
`ifdef STIM_SEQ_LOOP_EN
        test_loop();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 Parameter SW_W, default 16, SHALL set the width of the switch-value output S.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of step-table entries; it SHALL be a power of two and at least 2.
REQ-003 Parameter DELAY_W, default 8, SHALL set the width of the per-step delay field.
REQ-004 Parameter PULSE_LEN, default 4, SHALL set the button-pulse length in cycles; it SHALL be at least 1.
REQ-005 Entry format, MSB to LSB, SHALL be {end, pulse_cont, pulse_run, sw[SW_W-1:0], delay[DELAY_W-1:0]}, and ENTRY_W SHALL equal SW_W+DELAY_W+3.
REQ-006 Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-007 Reset  input  1  SHALL be a synchronous, active-low reset.
REQ-008 start  input  1  SHALL be a level that begins a run when sampled high in IDLE or DONE.
REQ-009 abort  input  1  SHALL return the block to IDLE when sampled high.
REQ-010 wr_en, wr_addr, wr_data  input  1 / log2(DEPTH) / ENTRY_W  SHALL form the step-table write port.
REQ-011 S  output  SW_W  SHALL be the registered switch value presented to the CPU.
REQ-012 Run, Continue  output  1 each  SHALL be active-low button outputs, idle high.
REQ-013 busy, done  output  1 each  SHALL be the status flags.
REQ-014 step_idx  output  log2(DEPTH)  SHALL be the index of the current step.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LOAD, WAIT, APPLY, PULSE, NEXT and DONE.
REQ-016 From IDLE or DONE, start=1 SHALL clear idx, clear done and enter LOAD on the next cycle.
REQ-017 LOAD SHALL last 1 cycle, latch entry[idx] and load delay into the counter; it SHALL go to WAIT if delay is nonzero and to APPLY if delay is 0.
REQ-018 WAIT SHALL decrement the counter each cycle and exit to APPLY after exactly delay cycles in WAIT.
REQ-019 APPLY SHALL last 1 cycle and register S <= sw; it SHALL go to PULSE if pulse_run or pulse_cont is set, else to NEXT.
REQ-020 In PULSE, Run SHALL be 0 iff pulse_run and Continue SHALL be 0 iff pulse_cont, for exactly PULSE_LEN cycles; both SHALL then return to 1 and the FSM SHALL enter NEXT.
REQ-021 NEXT SHALL go to DONE if end=1 or idx==DEPTH-1 (no wrap); otherwise it SHALL increment idx and go to LOAD.
REQ-022 DONE SHALL hold done=1, keep S at its last value, and hold Run and Continue at 1.
REQ-023 busy SHALL be 1 in every state except IDLE and DONE.
REQ-024 Table writes SHALL take effect when busy=0; writes while busy=1 SHALL be ignored.
REQ-025 abort=1 in any state SHALL force IDLE next cycle, with Run=Continue=1, done=0 and S held.
REQ-026 When start and abort are both high, abort SHALL win.
REQ-027 A write and start in the same cycle SHALL commit the write before the run begins, so step 0 sees the new data.

Reset
REQ-028 Reset=0 on a rising edge SHALL force IDLE, S=0, Run=1, Continue=1, busy=0, done=0, step_idx=0 and counter=0.
REQ-029 Reset SHALL NOT clear the step table, and Reset mid-run SHALL behave identically to REQ-028.

Configuration
REQ-030 With STIM_SEQ_LOOP_EN defined, NEXT SHALL wrap idx to 0 and re-enter LOAD on end=1 instead of entering DONE, repeating until abort; done SHALL never assert in this mode.
REQ-031 Without STIM_SEQ_LOOP_EN, behaviour SHALL be exactly as REQ-021.

Verification
REQ-032 Write entry0={end0,run1,sw=0x0003,delay=2}, entry1={end1,cont1,sw=0x0001,delay=0}, then pulse start -> S=0x0003 at APPLY cycle 5 after start; Run low 4 cycles; S=0x0001; Continue low 4 cycles; done=1.
REQ-033 Start a run, then assert Reset=0 for 1 cycle during PULSE -> next cycle: Run=1, S=0, busy=0; the table is unchanged on a rerun.
REQ-034 Start and abort asserted in the same cycle -> the block stays IDLE with busy=0.
REQ-035 Fill all 16 entries with end=0 -> the run completes after step 15 with step_idx=15 and done=1, and no wrap occurs.
REQ-036 wr_en asserted while busy -> the entry is unchanged, as confirmed by rerunning.
REQ-037 With STIM_SEQ_LOOP_EN, a 2-step table -> step_idx sequence 0,1,0,1, until abort returns the block to IDLE.
